// File: rtl/fpu_ss_mem_responder_if.sv
// ----------------------------------------------------------------------------
// fpu_ss_mem_responder_if
//   Bundle of the coprocessor memory request/result channel and the
//   data-memory bus seen by fpu_ss_mem_responder.
//
//   Handshakes:
//     x_mem request : x_mem_valid_i is held stable by the initiator until
//                     x_mem_ready_o is high in the same cycle; a request is
//                     consumed on any cycle where both are high.
//     x_mem result  : x_mem_result_valid_o has no ready; the initiator must
//                     take the result in the cycle it is presented.
//     data bus      : data_req_o stays high with stable fields until
//                     data_gnt_i; each granted access receives exactly one
//                     data_rvalid_i, in grant order.
//
//   Modports:
//     slave  - the responder (accepts x_mem requests, masters the data bus)
//     master - the environment (x_mem initiator plus data-memory model)
// ----------------------------------------------------------------------------
interface fpu_ss_mem_responder_if #(
   parameter int ID_WIDTH = 4
);
   logic                x_mem_valid_i;
   logic                x_mem_ready_o;
   logic [ID_WIDTH-1:0] x_mem_req_id_i;
   logic [31:0]         x_mem_req_addr_i;
   logic                x_mem_req_we_i;
   logic [1:0]          x_mem_req_size_i;
   logic [31:0]         x_mem_req_wdata_i;
   logic                x_mem_req_last_i;
   logic                x_mem_req_spec_i;
   logic                x_mem_resp_exc_o;
   logic [5:0]          x_mem_resp_exccode_o;
   logic                x_mem_result_valid_o;
   logic [ID_WIDTH-1:0] x_mem_result_id_o;
   logic [31:0]         x_mem_result_rdata_o;
   logic                x_mem_result_err_o;
   logic                data_req_o;
   logic                data_gnt_i;
   logic [31:0]         data_addr_o;
   logic                data_we_o;
   logic [3:0]          data_be_o;
   logic [31:0]         data_wdata_o;
   logic                data_rvalid_i;
   logic [31:0]         data_rdata_i;
   logic                data_err_i;

   modport slave (
      input  x_mem_valid_i, x_mem_req_id_i, x_mem_req_addr_i, x_mem_req_we_i,
             x_mem_req_size_i, x_mem_req_wdata_i, x_mem_req_last_i,
             x_mem_req_spec_i, data_gnt_i, data_rvalid_i, data_rdata_i,
             data_err_i,
      output x_mem_ready_o, x_mem_resp_exc_o, x_mem_resp_exccode_o,
             x_mem_result_valid_o, x_mem_result_id_o, x_mem_result_rdata_o,
             x_mem_result_err_o, data_req_o, data_addr_o, data_we_o,
             data_be_o, data_wdata_o
   );

   modport master (
      output x_mem_valid_i, x_mem_req_id_i, x_mem_req_addr_i, x_mem_req_we_i,
             x_mem_req_size_i, x_mem_req_wdata_i, x_mem_req_last_i,
             x_mem_req_spec_i, data_gnt_i, data_rvalid_i, data_rdata_i,
             data_err_i,
      input  x_mem_ready_o, x_mem_resp_exc_o, x_mem_resp_exccode_o,
             x_mem_result_valid_o, x_mem_result_id_o, x_mem_result_rdata_o,
             x_mem_result_err_o, data_req_o, data_addr_o, data_we_o,
             data_be_o, data_wdata_o
   );
endinterface

// File: rtl/fpu_ss_mem_responder.sv
// ----------------------------------------------------------------------------
// fpu_ss_mem_responder
//   Core-side responder for FPU subsystem loads/stores. Misaligned requests
//   are answered immediately with an exception. Aligned requests are passed
//   combinationally to the data bus; granted accesses are remembered in an
//   in-order FIFO so each bus response can be turned into a registered,
//   id-tagged, lane-extracted result one cycle after data_rvalid_i.
//
//   Ports:
//     clk_i   - clock
//     rst_ni  - asynchronous active-low reset
//     bus     - fpu_ss_mem_responder_if.slave (x_mem channel + data bus);
//               its ID_WIDTH must equal this module's ID_WIDTH
// ----------------------------------------------------------------------------
module fpu_ss_mem_responder #(
   parameter int ID_WIDTH          = 4,
   parameter int OUTSTANDING_DEPTH = 2
) (
   input  logic                  clk_i,
   input  logic                  rst_ni,
   fpu_ss_mem_responder_if.slave bus
);
   localparam int CNT_W = $clog2(OUTSTANDING_DEPTH + 1);
   localparam int PTR_W = (OUTSTANDING_DEPTH > 1) ? $clog2(OUTSTANDING_DEPTH) : 1;
   localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(OUTSTANDING_DEPTH);
   localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(OUTSTANDING_DEPTH - 1);

   // Outstanding-transaction FIFO storage (data only, no reset needed).
   logic [ID_WIDTH-1:0] fifo_id   [OUTSTANDING_DEPTH];
   logic                fifo_we   [OUTSTANDING_DEPTH];
   logic [1:0]          fifo_off  [OUTSTANDING_DEPTH];
   logic [1:0]          fifo_size [OUTSTANDING_DEPTH];
   logic [PTR_W-1:0]    wr_ptr, rd_ptr;
   logic [CNT_W-1:0]    count;

   logic       valid, mis, push, pop;
   logic [1:0] size, off;
   logic [3:0] base_be;
   logic [31:0] head_shifted, head_rdata;

   // last/spec carry no behaviour.
   logic unused_ok;
   assign unused_ok = bus.x_mem_req_last_i ^ bus.x_mem_req_spec_i;

   assign valid = bus.x_mem_valid_i;
   assign size  = bus.x_mem_req_size_i;
   assign off   = bus.x_mem_req_addr_i[1:0];

   always_comb begin
      mis = 1'b0;
      case (size)
         2'd1:    mis = off[0];
         2'd2:    mis = (off != 2'd0);
         2'd3:    mis = 1'b1;
         default: mis = 1'b0;
      endcase
   end

   always_comb begin
      base_be = 4'b0000;
      case (size)
         2'd0:    base_be = 4'b0001;
         2'd1:    base_be = 4'b0011;
         2'd2:    base_be = 4'b1111;
         default: base_be = 4'b0000;
      endcase
   end

   // No bypass: a full FIFO blocks new requests even if a pop is in flight.
   assign bus.data_req_o = valid & ~mis & (count < DEPTH_C);
   assign push           = bus.data_req_o & bus.data_gnt_i;
   assign pop            = bus.data_rvalid_i & (count != '0);

   assign bus.x_mem_ready_o        = (valid & mis) | push;
   assign bus.x_mem_resp_exc_o     = valid & mis;
   assign bus.x_mem_resp_exccode_o = (valid & mis) ? (bus.x_mem_req_we_i ? 6'd6 : 6'd4) : 6'd0;

   // Bus fields are forced to zero while no request is presented.
   assign bus.data_addr_o  = valid ? {bus.x_mem_req_addr_i[31:2], 2'b00} : 32'd0;
   assign bus.data_be_o    = valid ? (base_be << off) : 4'd0;
   assign bus.data_wdata_o = valid ? (bus.x_mem_req_wdata_i << {off, 3'b000}) : 32'd0;
   assign bus.data_we_o    = valid & bus.x_mem_req_we_i;

   // Extract the addressed lane of the response for the FIFO head.
   always_comb begin
      head_shifted = bus.data_rdata_i >> {fifo_off[rd_ptr], 3'b000};
      head_rdata   = head_shifted;
      case (fifo_size[rd_ptr])
         2'd0:    head_rdata = {24'd0, head_shifted[7:0]};
         2'd1:    head_rdata = {16'd0, head_shifted[15:0]};
         default: head_rdata = head_shifted;
      endcase
      if (fifo_we[rd_ptr]) head_rdata = 32'd0;
   end

   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      return (p == LAST_PTR) ? '0 : p + 1'b1;
   endfunction

   always_ff @(posedge clk_i) begin
      if (push) begin
         fifo_id[wr_ptr]   <= bus.x_mem_req_id_i;
         fifo_we[wr_ptr]   <= bus.x_mem_req_we_i;
         fifo_off[wr_ptr]  <= off;
         fifo_size[wr_ptr] <= size;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= ptr_inc(wr_ptr);
         if (pop)  rd_ptr <= ptr_inc(rd_ptr);
         case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   // Registered result: one cycle after each accepted response.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         bus.x_mem_result_valid_o <= 1'b0;
         bus.x_mem_result_id_o    <= '0;
         bus.x_mem_result_rdata_o <= '0;
         bus.x_mem_result_err_o   <= 1'b0;
      end else begin
         bus.x_mem_result_valid_o <= pop;
         if (pop) begin
            bus.x_mem_result_id_o    <= fifo_id[rd_ptr];
            bus.x_mem_result_rdata_o <= head_rdata;
            bus.x_mem_result_err_o   <= bus.data_err_i;
         end
      end
   end

   // A response with nothing outstanding is a bus protocol violation; it is
   // ignored by the logic above.
   a_rvalid_with_outstanding: assert property (
      @(posedge clk_i) disable iff (!rst_ni) !(bus.data_rvalid_i && count == '0)
   ) else $warning("data_rvalid_i with no outstanding transaction ignored");

endmodule

// File: tb/tb_fpu_ss_mem_responder.sv
module tb_fpu_ss_mem_responder;
  localparam int IDW   = 4;
  localparam int DEPTH = 2;

  // ---------------- clock / reset ----------------
  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  fpu_ss_mem_responder_if #(.ID_WIDTH(IDW)) bus ();

  fpu_ss_mem_responder #(.ID_WIDTH(IDW), .OUTSTANDING_DEPTH(DEPTH)) dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus    (bus)
  );

  // ---------------- reference model ----------------
  typedef struct {
    logic [IDW-1:0] id;
    bit             we;
    int unsigned    off;
    int unsigned    size;
  } ent_t;

  ent_t           out_q[$];     // accesses granted but not yet answered
  bit             exp_rv;
  logic [IDW-1:0] exp_rid;
  logic [31:0]    exp_rdata;
  bit             exp_rerr;
  bit             last_accept;

  int tests  = 0;
  int failed = 0;

  function automatic int unsigned nbytes(input int unsigned size);
    return (size == 0) ? 1 : (size == 1) ? 2 : 4;
  endfunction

  function automatic bit ref_mis(input int unsigned size, input logic [31:0] addr);
    return (size == 3) || (size == 1 && addr % 2 != 0) || (size == 2 && addr % 4 != 0);
  endfunction

  function automatic logic [3:0] ref_be(input int unsigned size, input int unsigned off);
    int unsigned m;
    m = (1 << nbytes(size)) - 1;
    return 4'((m << off) & 15);
  endfunction

  function automatic logic [31:0] ref_wdata(input logic [31:0] wd, input int unsigned off);
    longint unsigned w;
    w = 64'(wd) << (8 * off);
    return w[31:0];
  endfunction

  function automatic logic [31:0] ref_rdata(input logic [31:0] rd, input ent_t e);
    longint unsigned r;
    if (e.we) return 32'd0;
    r = 64'(rd) >> (8 * e.off);
    r = r & ((64'd1 << (8 * nbytes(e.size))) - 1);
    return r[31:0];
  endfunction

  // ---------------- scoreboard check ----------------
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic req(input bit v, input logic [IDW-1:0] id, input logic [31:0] a,
                     input bit we, input logic [1:0] sz, input logic [31:0] wd);
    bus.x_mem_valid_i     = v;
    bus.x_mem_req_id_i    = id;
    bus.x_mem_req_addr_i  = a;
    bus.x_mem_req_we_i    = we;
    bus.x_mem_req_size_i  = sz;
    bus.x_mem_req_wdata_i = wd;
    bus.x_mem_req_last_i  = 1'b1;
    bus.x_mem_req_spec_i  = 1'b0;
  endtask

  task automatic bus_in(input bit g, input bit rv, input logic [31:0] rd, input bit er);
    bus.data_gnt_i    = g;
    bus.data_rvalid_i = rv;
    bus.data_rdata_i  = rd;
    bus.data_err_i    = er;
  endtask

  // One clock: check every output against the model, then advance the model
  // on the rising edge. Entered and left at a falling edge.
  task automatic cycle();
    bit          v, mis, we, exp_req, exp_ready, exp_exc;
    int unsigned sz, off;
    logic [31:0] a;
    ent_t        e;
    #1;
    v   = (bus.x_mem_valid_i === 1'b1);
    a   = bus.x_mem_req_addr_i;
    sz  = bus.x_mem_req_size_i;
    off = a % 4;
    we  = bus.x_mem_req_we_i;
    mis = ref_mis(sz, a);
    exp_req   = v && !mis && (out_q.size() < DEPTH);
    exp_ready = v && (mis || (exp_req && bus.data_gnt_i));
    exp_exc   = v && mis;
    chk("data_req", bus.data_req_o, exp_req);
    chk("ready", bus.x_mem_ready_o, exp_ready);
    chk("exc", bus.x_mem_resp_exc_o, exp_exc);
    if (exp_exc) chk("exccode", bus.x_mem_resp_exccode_o, we ? 6 : 4);
    if (!v) begin
      chk("idle_exccode", bus.x_mem_resp_exccode_o, 0);
      chk("idle_addr", bus.data_addr_o, 0);
      chk("idle_be", bus.data_be_o, 0);
      chk("idle_wdata", bus.data_wdata_o, 0);
      chk("idle_we", bus.data_we_o, 0);
    end else if (!mis) begin
      chk("addr", bus.data_addr_o, a - off);
      chk("be", bus.data_be_o, ref_be(sz, off));
      chk("wdata", bus.data_wdata_o, ref_wdata(bus.x_mem_req_wdata_i, off));
      chk("we", bus.data_we_o, we);
    end
    chk("res_valid", bus.x_mem_result_valid_o, exp_rv);
    if (exp_rv) begin
      chk("res_id", bus.x_mem_result_id_o, exp_rid);
      chk("res_rdata", bus.x_mem_result_rdata_o, exp_rdata);
      chk("res_err", bus.x_mem_result_err_o, exp_rerr);
    end
    last_accept = exp_ready;
    @(posedge clk);
    if (!rst_n) begin
      out_q.delete();
      exp_rv = 0; exp_rid = '0; exp_rdata = '0; exp_rerr = 0;
    end else begin
      if (bus.data_rvalid_i && out_q.size() > 0) begin
        e         = out_q.pop_front();
        exp_rv    = 1;
        exp_rid   = e.id;
        exp_rdata = ref_rdata(bus.data_rdata_i, e);
        exp_rerr  = bus.data_err_i;
      end else begin
        exp_rv = 0;
      end
      if (exp_req && bus.data_gnt_i) begin
        e.id = bus.x_mem_req_id_i; e.we = we; e.off = off; e.size = sz;
        out_q.push_back(e);
      end
    end
    @(negedge clk);
  endtask

  task automatic reset_start(input int n);
    rst_n = 1'b0;
    out_q.delete();
    exp_rv = 0; exp_rid = '0; exp_rdata = '0; exp_rerr = 0;
    repeat (n) cycle();
    rst_n = 1'b1;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [1:0]  rsz;
    logic [31:0] raddr;
    int unsigned roff, r;

    req(0, '0, '0, 0, '0, '0);
    bus_in(0, 0, '0, 0);
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    reset_start(2);
    chk("reset_res_valid", bus.x_mem_result_valid_o, 0);
    chk("reset_res_id", bus.x_mem_result_id_o, 0);
    chk("reset_res_rdata", bus.x_mem_result_rdata_o, 0);
    chk("reset_res_err", bus.x_mem_result_err_o, 0);

    // Aligned word load, id 3 @0x100; rvalid two cycles after grant.
    req(1, 4'd3, 32'h100, 0, 2'd2, '0);
    bus_in(1, 0, '0, 0);
    #1;
    chk("t1_req", bus.data_req_o, 1);
    chk("t1_addr", bus.data_addr_o, 32'h100);
    chk("t1_be", bus.data_be_o, 4'hF);
    cycle();
    req(0, '0, '0, 0, '0, '0);
    bus_in(0, 0, '0, 0);
    cycle();
    bus_in(0, 1, 32'hDEADBEEF, 0);
    cycle();
    bus_in(0, 0, '0, 0);
    chk("t1_res_valid", bus.x_mem_result_valid_o, 1);
    chk("t1_res_id", bus.x_mem_result_id_o, 3);
    chk("t1_res_rdata", bus.x_mem_result_rdata_o, 32'hDEADBEEF);
    chk("t1_res_err", bus.x_mem_result_err_o, 0);
    cycle();

    // Byte store @0x103.
    req(1, 4'd5, 32'h103, 1, 2'd0, 32'hAB);
    bus_in(1, 0, '0, 0);
    #1;
    chk("t2_be", bus.data_be_o, 4'h8);
    chk("t2_wdata", bus.data_wdata_o, 32'hAB000000);
    chk("t2_we", bus.data_we_o, 1);
    cycle();
    req(0, '0, '0, 0, '0, '0);
    bus_in(0, 1, 32'h55667788, 0);
    cycle();
    bus_in(0, 0, '0, 0);
    chk("t2_res_valid", bus.x_mem_result_valid_o, 1);
    chk("t2_res_rdata", bus.x_mem_result_rdata_o, 0);

    // Halfword load @0x102.
    req(1, 4'd6, 32'h102, 0, 2'd1, '0);
    bus_in(1, 0, '0, 0);
    cycle();
    req(0, '0, '0, 0, '0, '0);
    bus_in(0, 1, 32'h1234ABCD, 0);
    cycle();
    bus_in(0, 0, '0, 0);
    chk("t3_res_rdata", bus.x_mem_result_rdata_o, 32'h00001234);
    chk("t3_res_id", bus.x_mem_result_id_o, 6);

    // Misaligned word load and store.
    req(1, 4'd7, 32'h101, 0, 2'd2, '0);
    bus_in(1, 0, '0, 0);
    #1;
    chk("t4_ready", bus.x_mem_ready_o, 1);
    chk("t4_exc", bus.x_mem_resp_exc_o, 1);
    chk("t4_code", bus.x_mem_resp_exccode_o, 4);
    chk("t4_req", bus.data_req_o, 0);
    cycle();
    req(1, 4'd8, 32'h102, 1, 2'd2, 32'h1);
    #1;
    chk("t5_code", bus.x_mem_resp_exccode_o, 6);
    chk("t5_exc", bus.x_mem_resp_exc_o, 1);
    cycle();
    req(0, '0, '0, 0, '0, '0);
    bus_in(0, 0, '0, 0);
    chk("t5_no_result", bus.x_mem_result_valid_o, 0);
    cycle();

    // Outstanding limit: three loads, gnt high, no rvalid.
    bus_in(1, 0, '0, 0);
    req(1, 4'd1, 32'h200, 0, 2'd2, '0);
    cycle();
    req(1, 4'd2, 32'h204, 0, 2'd2, '0);
    cycle();
    req(1, 4'd3, 32'h208, 0, 2'd2, '0);
    #1;
    chk("t6_full_req", bus.data_req_o, 0);
    chk("t6_full_ready", bus.x_mem_ready_o, 0);
    cycle();
    bus_in(1, 1, 32'h11111111, 0);
    #1;
    chk("t6_no_bypass", bus.data_req_o, 0);
    cycle();
    chk("t6_res1", bus.x_mem_result_id_o, 1);
    bus_in(1, 0, '0, 0);
    #1;
    chk("t6_third_req", bus.data_req_o, 1);
    cycle();
    req(0, '0, '0, 0, '0, '0);
    bus_in(0, 1, 32'h22222222, 0);
    cycle();
    chk("t6_res2", bus.x_mem_result_id_o, 2);
    bus_in(0, 1, 32'h33333333, 0);
    cycle();
    chk("t6_res3_valid", bus.x_mem_result_valid_o, 1);
    chk("t6_res3", bus.x_mem_result_id_o, 3);
    chk("t6_res3_rdata", bus.x_mem_result_rdata_o, 32'h33333333);
    bus_in(0, 0, '0, 0);
    cycle();

    // Reset with two outstanding, then a stray rvalid.
    bus_in(1, 0, '0, 0);
    req(1, 4'd9, 32'h300, 0, 2'd2, '0);
    cycle();
    req(1, 4'd10, 32'h304, 0, 2'd2, '0);
    cycle();
    req(0, '0, '0, 0, '0, '0);
    bus_in(0, 0, '0, 0);
    reset_start(1);
    bus_in(0, 1, 32'hCAFEF00D, 0);
    cycle();
    bus_in(0, 0, '0, 0);
    chk("t7_no_result", bus.x_mem_result_valid_o, 0);
    bus_in(1, 0, '0, 0);
    req(1, 4'd11, 32'h400, 0, 2'd2, '0);
    cycle();
    req(1, 4'd12, 32'h404, 0, 2'd2, '0);
    #1;
    chk("t7_count_cleared", bus.data_req_o, 1);
    cycle();
    req(0, '0, '0, 0, '0, '0);
    bus_in(0, 1, 32'hA5A5A5A5, 1);
    cycle();
    chk("t7_res11", bus.x_mem_result_id_o, 11);
    chk("t7_res11_err", bus.x_mem_result_err_o, 1);
    bus_in(0, 1, 32'h5A5A5A5A, 0);
    cycle();
    chk("t7_res12", bus.x_mem_result_id_o, 12);
    bus_in(0, 0, '0, 0);
    cycle();

    // Randomized traffic against the model.
    last_accept = 1;
    for (int i = 0; i < 600; i++) begin
      if (!bus.x_mem_valid_i || last_accept) begin
        r    = $urandom_range(0, 9);
        rsz  = (r < 3) ? 2'd0 : (r < 6) ? 2'd1 : (r < 9) ? 2'd2 : 2'd3;
        roff = $urandom_range(0, 3);
        if ($urandom_range(0, 3) != 0)
          roff = (rsz == 2'd0) ? roff : (rsz == 2'd1) ? (roff & 2) : 0;
        raddr = 32'h1000 + ($urandom_range(0, 255) << 2) + roff;
        req($urandom_range(0, 3) != 0, 4'($urandom_range(0, 15)), raddr,
            1'($urandom_range(0, 1)), rsz, $urandom);
      end
      bus_in($urandom_range(0, 2) != 0,
             (out_q.size() > 0) && ($urandom_range(0, 1) == 1),
             $urandom, $urandom_range(0, 7) == 0);
      cycle();
    end
    req(0, '0, '0, 0, '0, '0);
    bus_in(0, 0, '0, 0);
    cycle();

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end
endmodule
